regfile_dump: RTL and testbench

// - Read-side sequencer for the 8x16 register file: on a start pulse, walks a contiguous

---
 rtl/regfile_dump_if.sv | 29 ++
 rtl/regfile_dump.sv | 121 ++++++++++++
 tb/tb_regfile_dump.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Bus bundle for regfile_dump: start request, regfile read port, word stream and status.
// Parameters mirror the sequencer: k = word width, AW = register-number width.
interface regfile_dump_if #(
    parameter int k  = 16,
    parameter int AW = 3
);
    logic          start;
    logic [AW-1:0] start_num;
    logic [AW-1:0] len_m1;
    logic [AW-1:0] readnum;
    logic [k-1:0]  rf_data;
    logic [k-1:0]  out_data;
    logic [AW-1:0] out_num;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [k-1:0]  csum;

    modport master (
        output start, start_num, len_m1, rf_data, out_ready,
        input  readnum, out_data, out_num, out_valid, busy, done, csum
    );

    modport slave (
        input  start, start_num, len_m1, rf_data, out_ready,
        output readnum, out_data, out_num, out_valid, busy, done, csum
    );
endinterface

// File: rtl/regfile_dump.sv
// Read-side sequencer that walks a wrapping range of register numbers and streams each word.
// Optional running checksum enabled by defining REGFILE_DUMP_CSUM_EN.
module regfile_dump #(
    parameter int k    = 16,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input logic           clk,
    input logic           reset,
    regfile_dump_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] remaining_r;
    logic [AW-1:0] out_num_r;
    logic [k-1:0]  out_data_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          done_r;
    logic          handshake_s;

    assign handshake_s = out_valid_r & bus.out_ready;

    // Sequencer FSM; idx_r doubles as the regfile read address so readnum moves only on capture/accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            idx_r       <= {AW{1'b0}};
            remaining_r <= {AW{1'b0}};
            out_num_r   <= {AW{1'b0}};
            out_data_r  <= {k{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        idx_r       <= bus.start_num;
                        remaining_r <= bus.len_m1;
                        busy_r      <= 1'b1;
                        state_r     <= S_FETCH;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    out_data_r  <= bus.rf_data;
                    out_num_r   <= idx_r;
                    out_valid_r <= 1'b1;
                    state_r     <= S_SEND;
                end
                S_SEND: begin
                    if (handshake_s) begin
                        out_valid_r <= 1'b0;
                        if (remaining_r == {AW{1'b0}}) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            // Explicit wrap keeps the walk modulo NREG independent of AW.
                            idx_r       <= (idx_r == LAST_IDX) ? {AW{1'b0}} : idx_r + AW'(1);
                            remaining_r <= remaining_r - AW'(1);
                            state_r     <= S_FETCH;
                        end
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef REGFILE_DUMP_CSUM_EN
    logic [k-1:0] csum_r;

    // Running checksum: cleared on an accepted start, accumulates each accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_r <= {k{1'b0}};
        end else if ((state_r == S_IDLE) && bus.start) begin
            csum_r <= {k{1'b0}};
        end else if ((state_r == S_SEND) && handshake_s) begin
            csum_r <= csum_r + out_data_r;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign bus.csum = csum_r;
`else
    assign bus.csum = {k{1'b0}};
`endif

    assign bus.readnum   = idx_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_num   = out_num_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register-file model plus a per-dump word/checksum model.
module tb_regfile_dump;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_dump_if #(.k(16), .AW(3)) bus ();

    logic [15:0] rf [8];
    assign bus.rf_data = rf[bus.readnum];

    regfile_dump #(.k(16), .NREG(8), .AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Drives one dump and checks every cycle against the expected word order and protocol.
    task automatic dump(input logic [2:0] sn, input logic [2:0] lm, input int stall_pct,
                        input int stall_num, input int stall_len, input int inject_k,
                        input bit inject_done, input string tag);
        int          n;
        int          stalls;
        bit          rdy;
        logic [2:0]  idx;
        logic [15:0] sum;
        logic [15:0] exp_cs;
        n   = int'(lm) + 1;
        sum = 16'h0;
        bus.start = 1'b1; bus.start_num = sn; bus.len_m1 = lm; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.start_num = 3'($urandom); bus.len_m1 = 3'($urandom);
        for (int w = 0; w < n; w++) begin
            idx = 3'(sn + 3'(w));
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.readnum !== idx)
                begin errors++; $display("FAIL %s fetch w=%0d: valid=%b busy=%b done=%b readnum=%0d, required 0/1/0 readnum=%0d",
                    tag, w, bus.out_valid, bus.busy, bus.done, bus.readnum, idx); end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            stalls = 0;
            forever begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== rf[idx] || bus.out_num !== idx ||
                    bus.readnum !== idx || bus.done !== 1'b0 || bus.busy !== 1'b1)
                    begin errors++; $display("FAIL %s send w=%0d: valid=%b data=%h num=%0d readnum=%0d done=%b busy=%b, required 1 %h %0d %0d 0 1",
                        tag, w, bus.out_valid, bus.out_data, bus.out_num, bus.readnum, bus.done, bus.busy, rf[idx], idx, idx); end
                if (int'(idx) == stall_num) rdy = (stalls >= stall_len);
                else rdy = (int'($urandom_range(0, 99)) >= stall_pct) || (stalls >= 6);
                if (w == inject_k && stalls == 0) begin
                    bus.start = 1'b1; bus.start_num = 3'd4; bus.len_m1 = 3'($urandom);
                end
                bus.out_ready = rdy;
                @(negedge clk);
                bus.start = 1'b0;
                if (rdy) break;
                stalls++;
            end
            sum = 16'(sum + rf[idx]);
        end
`ifdef REGFILE_DUMP_CSUM_EN
        exp_cs = sum;
`else
        exp_cs = 16'h0;
`endif
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL %s done_cycle: done=%b busy=%b valid=%b, required 1 1 0",
                tag, bus.done, bus.busy, bus.out_valid); end
        checks++;
        if (bus.csum !== exp_cs)
            begin errors++; $display("FAIL %s csum_done: got %h, required %h", tag, bus.csum, exp_cs); end
        if (inject_done) begin
            bus.start = 1'b1; bus.start_num = 3'($urandom); bus.len_m1 = 3'($urandom);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL %s idle_after: done=%b busy=%b valid=%b, required 0 0 0",
                tag, bus.done, bus.busy, bus.out_valid); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.csum !== exp_cs)
            begin errors++; $display("FAIL %s idle_hold: busy=%b csum=%h, required 0 %h",
                tag, bus.busy, bus.csum, exp_cs); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.readnum !== 3'd0 ||
            bus.out_data !== 16'h0 || bus.out_num !== 3'd0 || bus.csum !== 16'h0)
            begin errors++; $display("FAIL reset: valid=%b busy=%b done=%b readnum=%0d data=%h num=%0d csum=%h, required all zero",
                bus.out_valid, bus.busy, bus.done, bus.readnum, bus.out_data, bus.out_num, bus.csum); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i);
        dump(3'd0, 3'd7, 0, -1, 0, -1, 1'b0, "full");
    endtask

    task automatic test_wrap();
        dump(3'd6, 3'd3, 0, -1, 0, -1, 1'b0, "wrap");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        dump(3'd0, 3'd7, 0, 2, 5, -1, 1'b0, "stall_r2");
    endtask

    task automatic test_busy_start();
        dump(3'd0, 3'd7, 0, -1, 0, 1, 1'b1, "busy_start");
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.start_num = 3'd1; bus.len_m1 = 3'd7; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_num !== 3'd1)
            begin errors++; $display("FAIL mid_send: valid=%b num=%0d, required 1 1", bus.out_valid, bus.out_num); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.readnum !== 3'd0 || bus.done !== 1'b0 || bus.csum !== 16'h0)
            begin errors++; $display("FAIL mid_reset: valid=%b busy=%b readnum=%0d done=%b csum=%h, required 0 0 0 0 0",
                bus.out_valid, bus.busy, bus.readnum, bus.done, bus.csum); end
        reset = 1'b0;
        @(negedge clk);
        dump(3'd5, 3'd2, 0, -1, 0, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            dump(3'($urandom), 3'($urandom), 30, -1, 0, -1, 1'b0, "random");
        end
    endtask

    task automatic test_csum();
        rf[0] = 16'hFFFF;
        for (int i = 1; i < 8; i++) rf[i] = 16'(i);
        dump(3'd0, 3'd7, 0, -1, 0, -1, 1'b0, "csum");
`ifdef REGFILE_DUMP_CSUM_EN
        checks++;
        if (bus.csum !== 16'h001B)
            begin errors++; $display("FAIL csum_wrap: got %h, required 001b", bus.csum); end
`else
        checks++;
        if (bus.csum !== 16'h0000)
            begin errors++; $display("FAIL csum_off: got %h, required 0000", bus.csum); end
`endif
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.start_num = 3'd0; bus.len_m1 = 3'd0; bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        test_reset();
        test_full_dump();
        test_wrap();
        test_stall();
        test_busy_start();
        test_reset_mid();
        test_random();
        test_csum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
